// File: rtl/fm_bank_if.sv
// Fast-memory bank bus: APR address, CON write strobes and EDP read/status signals.
// Master drives the request side; slave (fm_bank) drives data and status.
interface fm_bank_if #(
  parameter int WIDTH = 36,
  parameter int BLKW  = 3
);
  logic [BLKW-1:0]   fmBlk;
  logic [3:0]        fmAdr;
  logic              fmWriteL;
  logic              fmWriteR;
  logic [WIDTH-1:0]  fmWriteData;
  logic              fmReadEn;
  logic              fmParityInject;
  logic              fmInitReq;
  logic              fmErrClr;
  logic [WIDTH-1:0]  fmData;
  logic              fmParity;
  logic              fmParityErr;
  logic [BLKW+3:0]   fmErrAdr;
  logic              fmInitBusy;

  modport master (
    output fmBlk, fmAdr, fmWriteL, fmWriteR, fmWriteData, fmReadEn,
           fmParityInject, fmInitReq, fmErrClr,
    input  fmData, fmParity, fmParityErr, fmErrAdr, fmInitBusy
  );

  modport slave (
    input  fmBlk, fmAdr, fmWriteL, fmWriteR, fmWriteData, fmReadEn,
           fmParityInject, fmInitReq, fmErrClr,
    output fmData, fmParity, fmParityErr, fmErrAdr, fmInitBusy
  );
endinterface

// File: rtl/fm_bank.sv
// Parametrised EBOX fast-memory (AC) bank with per-half odd parity, sticky error
// capture and a zeroing init sweep after reset or on request.
module fm_bank #(
  parameter int WIDTH = 36,
  parameter int NBLKS = 8,
  parameter int BLKW  = 3
) (
  input  logic      eboxClk,
  input  logic      eboxReset_n,
  fm_bank_if.slave  fm
);
  localparam int HALF  = WIDTH / 2;
  localparam int ADRW  = BLKW + 4;
  localparam int DEPTH = NBLKS * 16;

  typedef enum logic {ST_IDLE, ST_INIT} state_e;

  state_e            state_q, state_d;
  logic [ADRW-1:0]   cnt_q, cnt_d;
  logic              busy;

  // Parity bit [1] covers the left half, bit [0] the right half.
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [1:0]        par_q [DEPTH];

  logic [WIDTH-1:0]  data_q, data_d;
  logic              err_q, err_d;
  logic [ADRW-1:0]   eadr_q, eadr_d;

  logic [ADRW-1:0]   adr;
  logic              wl, wr, npl, npr, mismatch;
  logic [WIDTH-1:0]  byp_word;
  logic [1:0]        byp_par;

  function automatic logic half_par(input logic [HALF-1:0] h);
    return ~^h;
  endfunction

  always_ff @(posedge eboxClk) begin
    if (!eboxReset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: if (fm.fmInitReq) state_d = ST_INIT;
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADRW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      ST_INIT: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Write-first bypass per half: a written half reads back its new data and parity.
  always_comb begin
    adr      = {fm.fmBlk, fm.fmAdr};
    wl       = fm.fmWriteL & ~busy;
    wr       = fm.fmWriteR & ~busy;
    npl      = half_par(fm.fmWriteData[WIDTH-1:HALF]) ^ fm.fmParityInject;
    npr      = half_par(fm.fmWriteData[HALF-1:0]) ^ fm.fmParityInject;
    byp_word = mem_q[adr];
    byp_par  = par_q[adr];
    if (wl) begin
      byp_word[WIDTH-1:HALF] = fm.fmWriteData[WIDTH-1:HALF];
      byp_par[1]             = npl;
    end
    if (wr) begin
      byp_word[HALF-1:0] = fm.fmWriteData[HALF-1:0];
      byp_par[0]         = npr;
    end
    mismatch = fm.fmReadEn & ~busy &
               ((byp_par[1] != half_par(byp_word[WIDTH-1:HALF])) |
                (byp_par[0] != half_par(byp_word[HALF-1:0])));
    data_d   = busy ? '0 : byp_word;
    err_d    = mismatch | (err_q & ~fm.fmErrClr);
    eadr_d   = (mismatch & ~err_q) ? adr : eadr_q;
  end

  // The array is never touched on a reset edge, even mid-sweep.
  always_ff @(posedge eboxClk) begin
    if (eboxReset_n) begin
      if (busy) begin
        mem_q[cnt_q] <= '0;
        par_q[cnt_q] <= 2'b11;
      end else begin
        if (wl) begin
          mem_q[adr][WIDTH-1:HALF] <= fm.fmWriteData[WIDTH-1:HALF];
          par_q[adr][1]            <= npl;
        end
        if (wr) begin
          mem_q[adr][HALF-1:0] <= fm.fmWriteData[HALF-1:0];
          par_q[adr][0]        <= npr;
        end
      end
    end
  end

  always_ff @(posedge eboxClk) begin
    if (!eboxReset_n) begin
      data_q <= '0;
      err_q  <= 1'b0;
      eadr_q <= '0;
    end else begin
      data_q <= data_d;
      err_q  <= err_d;
      eadr_q <= eadr_d;
    end
  end

  assign fm.fmData      = data_q;
  assign fm.fmParity    = ~^data_q;
  assign fm.fmParityErr = err_q;
  assign fm.fmErrAdr    = eadr_q;
  assign fm.fmInitBusy  = busy;
endmodule

// File: tb/tb_fm_bank.sv
// Bench for fm_bank: directed scenarios and random traffic against a per-location
// model of the fast memory, plus a small second instance with WIDTH=18, NBLKS=4.
module tb_fm_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  fm_bank_if #(.WIDTH(36), .BLKW(3)) bus ();
  fm_bank_if #(.WIDTH(18), .BLKW(2)) bus2 ();

  fm_bank #(.WIDTH(36), .NBLKS(8), .BLKW(3)) dut (
    .eboxClk(clk), .eboxReset_n(rst_n), .fm(bus));
  fm_bank #(.WIDTH(18), .NBLKS(4), .BLKW(2)) dut2 (
    .eboxClk(clk), .eboxReset_n(rst2_n), .fm(bus2));

  int n_vec = 0;
  int n_bad = 0;

  logic [35:0] m_mem [128];
  logic [1:0]  m_par [128];
  int          m_busy = 0;
  int          m_cnt = 0;
  logic        m_err = 1'b0;
  logic [6:0]  m_eadr = '0;
  logic [35:0] m_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the inputs currently on the bus for one edge and check every output.
  task automatic step();
    int a;
    logic [17:0] lh, rh;
    logic mis;
    if (!rst_n) begin
      m_data = '0; m_err = 1'b0; m_eadr = '0; m_busy = 128; m_cnt = 0;
    end else if (m_busy > 0) begin
      m_mem[m_cnt] = '0;
      m_par[m_cnt] = 2'b11;
      m_cnt++;
      m_busy--;
      m_data = '0;
      if (bus.fmErrClr) m_err = 1'b0;
    end else begin
      a = int'({bus.fmBlk, bus.fmAdr});
      if (bus.fmWriteL) begin
        m_mem[a][35:18] = bus.fmWriteData[35:18];
        m_par[a][1] = (~^bus.fmWriteData[35:18]) ^ bus.fmParityInject;
      end
      if (bus.fmWriteR) begin
        m_mem[a][17:0] = bus.fmWriteData[17:0];
        m_par[a][0] = (~^bus.fmWriteData[17:0]) ^ bus.fmParityInject;
      end
      lh = m_mem[a][35:18];
      rh = m_mem[a][17:0];
      mis = bus.fmReadEn && ((m_par[a][1] != ~^lh) || (m_par[a][0] != ~^rh));
      m_data = m_mem[a];
      if (mis && !m_err) m_eadr = 7'(a);
      if (mis) m_err = 1'b1;
      else if (bus.fmErrClr) m_err = 1'b0;
      if (bus.fmInitReq) begin m_busy = 128; m_cnt = 0; end
    end
    @(posedge clk); #1;
    chk("data",   64'(bus.fmData),      64'(m_data));
    chk("parity", 64'(bus.fmParity),    64'(~^m_data));
    chk("perr",   64'(bus.fmParityErr), 64'(m_err));
    chk("eadr",   64'(bus.fmErrAdr),    64'(m_eadr));
    chk("busy",   64'(bus.fmInitBusy),  64'(m_busy > 0));
  endtask

  task automatic drv(input int blk, input int adr, input logic wl, input logic wr,
                     input logic [35:0] d, input logic ren, input logic inj,
                     input logic ireq, input logic clr);
    bus.fmBlk = blk[2:0]; bus.fmAdr = adr[3:0];
    bus.fmWriteL = wl; bus.fmWriteR = wr; bus.fmWriteData = d;
    bus.fmReadEn = ren; bus.fmParityInject = inj;
    bus.fmInitReq = ireq; bus.fmErrClr = clr;
    step();
  endtask

  task automatic idle();
    drv(0, 0, 1'b0, 1'b0, 36'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic count_busy(input int expect_len);
    int n = 0;
    for (int i = 0; i < 300 && bus.fmInitBusy === 1'b1; i++) begin
      n++;
      idle();
    end
    chk("busy_len", 64'(n), 64'(expect_len));
  endtask

  initial begin
    logic [63:0] r;
    logic [17:0] w2;
    int n2;
    for (int i = 0; i < 128; i++) begin m_mem[i] = '0; m_par[i] = 2'b11; end
    bus2.fmBlk = '0; bus2.fmAdr = '0; bus2.fmWriteL = 1'b0; bus2.fmWriteR = 1'b0;
    bus2.fmWriteData = '0; bus2.fmReadEn = 1'b0; bus2.fmParityInject = 1'b0;
    bus2.fmInitReq = 1'b0; bus2.fmErrClr = 1'b0;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) idle();
    rst_n = 1'b1;
    count_busy(128);
    drv(7, 15, 1'b0, 1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    drv(2, 5, 1'b1, 1'b1, 36'o123456654321, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(2, 5, 1'b0, 1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr_rd", 64'(bus.fmData), 64'(36'o123456654321));

    drv(3, 1, 1'b1, 1'b1, 36'o777777000000, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(3, 1, 1'b0, 1'b1, 36'o000000000123, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("half_byp", 64'(bus.fmData), 64'(36'o777777000123));

    drv(0, 3, 1'b1, 1'b1, 36'o000000000007, 1'b0, 1'b1, 1'b0, 1'b0);
    drv(0, 3, 1'b0, 1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("inj_err", 64'(bus.fmParityErr), 64'd1);
    chk("inj_adr", 64'(bus.fmErrAdr), 64'(7'd3));
    drv(1, 4, 1'b1, 1'b0, 36'o555555000000, 1'b0, 1'b1, 1'b0, 1'b0);
    drv(1, 4, 1'b0, 1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("first_adr", 64'(bus.fmErrAdr), 64'(7'd3));
    drv(0, 3, 1'b0, 1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("set_wins", 64'(bus.fmParityErr), 64'd1);
    drv(2, 5, 1'b0, 1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    drv(0, 0, 1'b0, 1'b0, 36'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++)
      drv(0, 0, 1'b1, 1'b1, 36'o111111111111, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    count_busy(128);
    for (int i = 0; i < 128; i++)
      drv(i / 16, i % 16, 1'b0, 1'b0, 36'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sweep_clean", 64'(bus.fmParityErr), 64'd0);

    for (int i = 0; i < 800; i++) begin
      r = {$urandom(), $urandom()};
      drv(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), r[35:0],
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 7) == 0));
    end

    @(posedge clk); #1;
    rst2_n = 1'b1;
    n2 = 0;
    for (int i = 0; i < 300 && bus2.fmInitBusy === 1'b1; i++) begin
      n2++;
      @(posedge clk); #1;
    end
    chk("busy_len2", 64'(n2), 64'd64);
    bus2.fmBlk = 2'd1; bus2.fmAdr = 4'd2; bus2.fmWriteL = 1'b1;
    bus2.fmWriteData = {9'h0A5, 9'h1FF}; bus2.fmReadEn = 1'b1;
    @(posedge clk); #1;
    w2 = {9'h0A5, 9'h000};
    chk("w18_byp", 64'(bus2.fmData), 64'(w2));
    chk("w18_par", 64'(bus2.fmParity), 64'(~^w2));
    bus2.fmWriteL = 1'b0;
    @(posedge clk); #1;
    chk("w18_rd", 64'(bus2.fmData), 64'(w2));
    chk("w18_ok", 64'(bus2.fmParityErr), 64'd0);
    bus2.fmWriteR = 1'b1; bus2.fmParityInject = 1'b1; bus2.fmReadEn = 1'b0;
    @(posedge clk); #1;
    bus2.fmWriteR = 1'b0; bus2.fmParityInject = 1'b0; bus2.fmReadEn = 1'b1;
    @(posedge clk); #1;
    w2 = {9'h0A5, 9'h1FF};
    chk("w18_rd2", 64'(bus2.fmData), 64'(w2));
    chk("w18_err", 64'(bus2.fmParityErr), 64'd1);
    chk("w18_eadr", 64'(bus2.fmErrAdr), 64'(6'h12));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
